rrf_alloc_ctrl: RTL and testbench
=================================

RRF_ALLOC_CTRL -- requirements
Module: rrf_alloc_ctrl

Interface
REQ-001 Parameter RRF_NUM, default 64, number of rename-register-file entries (power of two, >=4).
REQ-002 Parameter RRF_SEL, default 6, log2(RRF_NUM); tag width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  1  dispatch requests destination entries this cycle.
REQ-006 req_num_i  in  2  entries requested, 1..2 when req_valid_i=1.
REQ-007 com_inst_num_i  in  2  entries released by commit this cycle, 0..2.
REQ-008 flush_i  in  1  mispredict rollback request.
REQ-009 flush_rrftag_i  in  RRF_SEL  first entry to discard on flush.
REQ-010 grant_o  out  1  allocation accepted this cycle (combinational).
REQ-011 stall_dp_o  out  1  dispatch must hold its instructions this cycle.
REQ-012 alloc_tag0_o / alloc_tag1_o  out  RRF_SEL each  tags for first/second destination.
REQ-013 freenum_o  out  RRF_SEL+1  free entry count (registered).
REQ-014 rrfptr_o / comptr_o  out  RRF_SEL each  allocation / commit head pointers (registered).
REQ-015 nextrrfcyc_o  out  1  rrfptr wrapped on last update (registered).

Function
REQ-016 FSM states RUN and RECOVER; RUN->RECOVER when flush_i=1; RECOVER->RUN unconditionally after one cycle.
REQ-017 grant_o = state RUN & req_valid_i & ~flush_i & (req_num_i <= freenum_o + com_inst_num_i), compare at RRF_SEL+2 bits.
REQ-018 stall_dp_o = (req_valid_i & ~grant_o) | state RECOVER | flush_i.
REQ-019 alloc_tag0_o = rrfptr_o; alloc_tag1_o = (rrfptr_o+1) mod RRF_NUM; valid only when grant_o=1.
REQ-020 comptr_o advances by com_inst_num_i mod RRF_NUM every cycle in every state.
REQ-021 On grant: rrfptr_o += req_num_i mod RRF_NUM; freenum_o += com_inst_num_i - req_num_i.
REQ-022 RUN without grant and without flush: rrfptr_o holds; freenum_o += com_inst_num_i.
REQ-023 nextrrfcyc_o <= 1 only when a grant makes new rrfptr numerically less than old; else 0 (including stall, flush, RECOVER).
REQ-024 Flush cycle (RUN, flush_i=1): rrfptr_o <= flush_rrftag_i; freenum_o holds; no grant, request ignored.
REQ-025 RECOVER cycle: freenum_o <= RRF_NUM - ((rrfptr_o - comptr_next) mod RRF_NUM), comptr_next including this cycle's commits; rrfptr==comptr_next means freenum=RRF_NUM.
REQ-026 flush_i during RECOVER ignored.
REQ-027 Full (freenum_o=0) with same-cycle commits: commits count toward the grant check (REQ-017).
REQ-028 com_inst_num_i=3 or commit exceeding occupied entries is illegal; behaviour undefined, bench asserts.

Reset
REQ-029 reset_i=1 asynchronously forces state RUN, freenum_o=RRF_NUM, rrfptr_o=0, comptr_o=0, nextrrfcyc_o=0, perf counter 0; grant_o=0 while asserted.
REQ-030 Reset asserted mid-RECOVER abandons recovery; first post-reset cycle is RUN.

Configuration
REQ-031 Macro RRF_ALLOC_PERF_EN defined: adds output stall_cnt_o (32 bits), incremented each non-reset cycle stall_dp_o=1, saturating at all-ones.
REQ-032 Macro RRF_ALLOC_PERF_EN undefined: stall_cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-033 Release reset, req_valid=1 req_num=2 -> grant=1, tags 0/1; next cycle rrfptr=2, freenum=62.
REQ-034 32 cycles req_num=2, no commits -> freenum=0, rrfptr=0, nextrrfcyc=1 after final cycle; next req_num=1 com=0 -> grant=0, stall=1, state unchanged.
REQ-035 freenum=0, req_num=2, com=2 -> grant=1; freenum stays 0, comptr+=2.
REQ-036 rrfptr=63, req_num=2 -> tags 63/0; next rrfptr=1, nextrrfcyc=1.
REQ-037 comptr=10, rrfptr=30, flush tag 20, com=1 -> rrfptr=20, state RECOVER, stall=1; next cycle com=0 -> freenum=55, state RUN.
REQ-038 Assert reset_i asynchronously during RECOVER -> outputs reach reset values before next edge; perf build: stall_cnt_o=0.

Source files
------------

// File: rtl/rrf_alloc_ctrl.sv
// Rename-register-file allocation controller: hands out destination tags, tracks free entries, rolls back on flush.
// Optional stall performance counter (stall_cnt_o) is built only when RRF_ALLOC_PERF_EN is defined.
module rrf_alloc_ctrl #(
    parameter int RRF_NUM = 64,
    parameter int RRF_SEL = 6
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_valid_i,
    input  logic [1:0]         req_num_i,
    input  logic [1:0]         com_inst_num_i,
    input  logic               flush_i,
    input  logic [RRF_SEL-1:0] flush_rrftag_i,
    output logic               grant_o,
    output logic               stall_dp_o,
    output logic [RRF_SEL-1:0] alloc_tag0_o,
    output logic [RRF_SEL-1:0] alloc_tag1_o,
    output logic [RRF_SEL:0]   freenum_o,
    output logic [RRF_SEL-1:0] rrfptr_o,
    output logic [RRF_SEL-1:0] comptr_o,
`ifdef RRF_ALLOC_PERF_EN
    output logic [31:0]        stall_cnt_o,
`endif
    output logic               nextrrfcyc_o
);

    localparam int PW = RRF_SEL;
    localparam int FW = RRF_SEL + 1;
    localparam int CW = RRF_SEL + 2;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [FW-1:0] freenum_q, freenum_d;
    logic [PW-1:0] rrfptr_q, rrfptr_d;
    logic [PW-1:0] comptr_q, comptr_d;
    logic          nextrrfcyc_q, nextrrfcyc_d;

    logic [CW-1:0] avail;
    logic [PW-1:0] rrfptr_inc;
    logic [PW-1:0] occupied;
    logic          grant;

    // Commits retiring this cycle free entries in time to satisfy a same-cycle request.
    always_comb begin
        avail      = CW'(freenum_q) + CW'(com_inst_num_i);
        grant      = ~reset_i & (state_q == ST_RUN) & req_valid_i & ~flush_i
                     & (CW'(req_num_i) <= avail);
        stall_dp_o = (req_valid_i & ~grant) | (state_q == ST_RECOVER) | flush_i;
    end

    assign grant_o      = grant;
    assign alloc_tag0_o = rrfptr_q;
    assign alloc_tag1_o = rrfptr_q + PW'(1);
    assign freenum_o    = freenum_q;
    assign rrfptr_o     = rrfptr_q;
    assign comptr_o     = comptr_q;
    assign nextrrfcyc_o = nextrrfcyc_q;

    always_comb begin
        comptr_d     = comptr_q + PW'(com_inst_num_i);
        rrfptr_inc   = rrfptr_q + PW'(req_num_i);
        occupied     = rrfptr_q - comptr_d;
        state_d      = state_q;
        rrfptr_d     = rrfptr_q;
        freenum_d    = freenum_q;
        nextrrfcyc_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (flush_i) begin
                state_d  = ST_RECOVER;
                rrfptr_d = flush_rrftag_i;
            end else if (grant) begin
                rrfptr_d     = rrfptr_inc;
                freenum_d    = freenum_q + FW'(com_inst_num_i) - FW'(req_num_i);
                nextrrfcyc_d = (rrfptr_inc < rrfptr_q);
            end else begin
                freenum_d = freenum_q + FW'(com_inst_num_i);
            end
        end else begin
            // Free count is rebuilt from the surviving window between the pointers.
            state_d   = ST_RUN;
            freenum_d = FW'(RRF_NUM) - FW'(occupied);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            freenum_q    <= FW'(RRF_NUM);
            rrfptr_q     <= '0;
            comptr_q     <= '0;
            nextrrfcyc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            freenum_q    <= freenum_d;
            rrfptr_q     <= rrfptr_d;
            comptr_q     <= comptr_d;
            nextrrfcyc_q <= nextrrfcyc_d;
        end
    end

`ifdef RRF_ALLOC_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_dp_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Self-checking bench for rrf_alloc_ctrl: directed vectors, literal checks and a per-cycle reference model.
`timescale 1ns/1ps
module tb_rrf_alloc_ctrl;

    localparam int RRF_NUM = 64;
    localparam int RRF_SEL = 6;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               req_valid_i;
    logic [1:0]         req_num_i;
    logic [1:0]         com_inst_num_i;
    logic               flush_i;
    logic [RRF_SEL-1:0] flush_rrftag_i;
    logic               grant_o;
    logic               stall_dp_o;
    logic [RRF_SEL-1:0] alloc_tag0_o;
    logic [RRF_SEL-1:0] alloc_tag1_o;
    logic [RRF_SEL:0]   freenum_o;
    logic [RRF_SEL-1:0] rrfptr_o;
    logic [RRF_SEL-1:0] comptr_o;
    logic               nextrrfcyc_o;
`ifdef RRF_ALLOC_PERF_EN
    logic [31:0]        stall_cnt_o;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: plain integer bookkeeping of pointers and free count.
    int m_recover  = 0;
    int m_free     = RRF_NUM;
    int m_rrfptr   = 0;
    int m_comptr   = 0;
    int m_cyc      = 0;
    int m_stallcnt = 0;
    int m_illegal  = 0;

    rrf_alloc_ctrl #(.RRF_NUM(RRF_NUM), .RRF_SEL(RRF_SEL)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_num_i      (req_num_i),
        .com_inst_num_i (com_inst_num_i),
        .flush_i        (flush_i),
        .flush_rrftag_i (flush_rrftag_i),
        .grant_o        (grant_o),
        .stall_dp_o     (stall_dp_o),
        .alloc_tag0_o   (alloc_tag0_o),
        .alloc_tag1_o   (alloc_tag1_o),
        .freenum_o      (freenum_o),
        .rrfptr_o       (rrfptr_o),
        .comptr_o       (comptr_o),
`ifdef RRF_ALLOC_PERF_EN
        .stall_cnt_o    (stall_cnt_o),
`endif
        .nextrrfcyc_o   (nextrrfcyc_o)
    );

    always #10 clk_i = ~clk_i;

    function automatic int modelGrant();
        return (m_recover == 0 && req_valid_i && !flush_i &&
                int'(req_num_i) <= m_free + int'(com_inst_num_i)) ? 1 : 0;
    endfunction

    function automatic int modelStall();
        return ((req_valid_i && modelGrant() == 0) || m_recover != 0 || flush_i) ? 1 : 0;
    endfunction

    // Model advances on every clock edge, or resets immediately on reset assertion.
    initial begin
        forever begin
            @(posedge clk_i or posedge reset_i);
            if (reset_i) begin
                m_recover = 0; m_free = RRF_NUM; m_rrfptr = 0; m_comptr = 0;
                m_cyc = 0; m_stallcnt = 0;
            end else begin
                int g;
                int newPtr;
                g = modelGrant();
                if (modelStall() != 0) m_stallcnt = m_stallcnt + 1;
                if (m_recover == 0 && !flush_i && int'(com_inst_num_i) > RRF_NUM - m_free)
                    m_illegal = 1;
                if (com_inst_num_i == 2'd3) m_illegal = 1;
                m_comptr = (m_comptr + int'(com_inst_num_i)) % RRF_NUM;
                m_cyc = 0;
                if (m_recover != 0) begin
                    m_free = RRF_NUM - ((m_rrfptr - m_comptr + RRF_NUM) % RRF_NUM);
                    m_recover = 0;
                end else if (flush_i) begin
                    m_rrfptr = int'(flush_rrftag_i);
                    m_recover = 1;
                end else if (g != 0) begin
                    newPtr = (m_rrfptr + int'(req_num_i)) % RRF_NUM;
                    m_cyc = (newPtr < m_rrfptr) ? 1 : 0;
                    m_rrfptr = newPtr;
                    m_free = m_free + int'(com_inst_num_i) - int'(req_num_i);
                end else begin
                    m_free = m_free + int'(com_inst_num_i);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared = nCompared + 1;
        if (act !== exp) begin
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] n, input logic [1:0] c,
                                 input logic f, input logic [RRF_SEL-1:0] tag);
        req_valid_i    = v;
        req_num_i      = n;
        com_inst_num_i = c;
        flush_i        = f;
        flush_rrftag_i = tag;
    endtask

    // Per-cycle comparison against the model, taken on the falling edge.
    task automatic compareModel();
        int eg;
        eg = modelGrant();
        checkOutput("m_grant", 32'(grant_o), 32'(eg));
        checkOutput("m_stall", 32'(stall_dp_o), 32'(modelStall()));
        if (eg != 0) begin
            checkOutput("m_tag0", 32'(alloc_tag0_o), 32'(m_rrfptr));
            checkOutput("m_tag1", 32'(alloc_tag1_o), 32'((m_rrfptr + 1) % RRF_NUM));
        end
        checkOutput("m_freenum", 32'(freenum_o), 32'(m_free));
        checkOutput("m_rrfptr", 32'(rrfptr_o), 32'(m_rrfptr));
        checkOutput("m_comptr", 32'(comptr_o), 32'(m_comptr));
        checkOutput("m_nextrrfcyc", 32'(nextrrfcyc_o), 32'(m_cyc));
        checkOutput("m_illegal_commit", 32'(m_illegal), 32'd0);
`ifdef RRF_ALLOC_PERF_EN
        checkOutput("m_stall_cnt", stall_cnt_o, 32'(m_stallcnt));
`endif
    endtask

    task automatic step();
        @(negedge clk_i);
        if (!reset_i) compareModel();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, '0);
        #3;
        checkOutput("rst_grant", 32'(grant_o), 32'd0);
        checkOutput("rst_freenum", 32'(freenum_o), 32'd64);
        checkOutput("rst_rrfptr", 32'(rrfptr_o), 32'd0);
        checkOutput("rst_comptr", 32'(comptr_o), 32'd0);
        checkOutput("rst_nextrrfcyc", 32'(nextrrfcyc_o), 32'd0);
        #8;
        reset_i = 1'b0;
        applyStimulus(1'b1, 2'd2, 2'd0, 1'b0, '0);
        #1;
        checkOutput("first_grant", 32'(grant_o), 32'd1);
        checkOutput("first_tag0", 32'(alloc_tag0_o), 32'd0);
        checkOutput("first_tag1", 32'(alloc_tag1_o), 32'd1);
        step();
        checkOutput("first_rrfptr", 32'(rrfptr_o), 32'd2);
        checkOutput("first_freenum", 32'(freenum_o), 32'd62);

        for (int i = 0; i < 31; i++) step();
        checkOutput("fill_freenum", 32'(freenum_o), 32'd0);
        checkOutput("fill_rrfptr", 32'(rrfptr_o), 32'd0);
        checkOutput("fill_nextrrfcyc", 32'(nextrrfcyc_o), 32'd1);

        applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, '0);
        #1;
        checkOutput("full_grant", 32'(grant_o), 32'd0);
        checkOutput("full_stall", 32'(stall_dp_o), 32'd1);
        step();
        checkOutput("full_hold_rrfptr", 32'(rrfptr_o), 32'd0);
        checkOutput("full_hold_freenum", 32'(freenum_o), 32'd0);

        applyStimulus(1'b1, 2'd2, 2'd2, 1'b0, '0);
        #1;
        checkOutput("fullcom_grant", 32'(grant_o), 32'd1);
        step();
        checkOutput("fullcom_freenum", 32'(freenum_o), 32'd0);
        checkOutput("fullcom_comptr", 32'(comptr_o), 32'd2);

        applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, '0);
        step();
        applyStimulus(1'b1, 2'd2, 2'd2, 1'b0, '0);
        for (int i = 0; i < 30; i++) step();
        checkOutput("pre_wrap_rrfptr", 32'(rrfptr_o), 32'd63);
        #1;
        checkOutput("wrap_tag0", 32'(alloc_tag0_o), 32'd63);
        checkOutput("wrap_tag1", 32'(alloc_tag1_o), 32'd0);
        step();
        checkOutput("wrap_rrfptr", 32'(rrfptr_o), 32'd1);
        checkOutput("wrap_nextrrfcyc", 32'(nextrrfcyc_o), 32'd1);

        applyStimulus(1'b0, 2'd0, 2'd2, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();
        applyStimulus(1'b0, 2'd0, 2'd1, 1'b0, '0);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 6'd30);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, '0);
        step();
        checkOutput("setup_comptr", 32'(comptr_o), 32'd10);
        checkOutput("setup_rrfptr", 32'(rrfptr_o), 32'd30);
        checkOutput("setup_freenum", 32'(freenum_o), 32'd44);

        applyStimulus(1'b1, 2'd1, 2'd1, 1'b1, 6'd20);
        #1;
        checkOutput("flush_grant", 32'(grant_o), 32'd0);
        checkOutput("flush_stall", 32'(stall_dp_o), 32'd1);
        step();
        checkOutput("flush_rrfptr", 32'(rrfptr_o), 32'd20);
        applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, '0);
        #1;
        checkOutput("recover_stall", 32'(stall_dp_o), 32'd1);
        checkOutput("recover_grant", 32'(grant_o), 32'd0);
        step();
        checkOutput("recover_freenum", 32'(freenum_o), 32'd55);
        #1;
        checkOutput("post_recover_grant", 32'(grant_o), 32'd1);
        checkOutput("post_recover_tag0", 32'(alloc_tag0_o), 32'd20);
        step();

        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 6'd25);
        step();
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 6'd5);
        step();
        checkOutput("reflush_rrfptr", 32'(rrfptr_o), 32'd25);
        checkOutput("reflush_freenum", 32'(freenum_o), 32'd50);
        applyStimulus(1'b1, 2'd2, 2'd0, 1'b0, '0);
        #1;
        checkOutput("reflush_run_grant", 32'(grant_o), 32'd1);
        step();

        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 6'd12);
        step();
        applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, '0);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("async_rst_freenum", 32'(freenum_o), 32'd64);
        checkOutput("async_rst_rrfptr", 32'(rrfptr_o), 32'd0);
        checkOutput("async_rst_comptr", 32'(comptr_o), 32'd0);
        checkOutput("async_rst_grant", 32'(grant_o), 32'd0);
`ifdef RRF_ALLOC_PERF_EN
        checkOutput("async_rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
        #2;
        reset_i = 1'b0;
        #1;
        checkOutput("post_rst_grant", 32'(grant_o), 32'd1);
        checkOutput("post_rst_stall", 32'(stall_dp_o), 32'd0);
        step();
        checkOutput("post_rst_rrfptr", 32'(rrfptr_o), 32'd1);
        checkOutput("post_rst_freenum", 32'(freenum_o), 32'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
